// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period in clk cycles, reports a
// static line after an edge-free timeout, and decodes L298 direction pins.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             dir_a,
  input  logic             dir_b,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             static_det,
  output logic             static_lvl,
  output logic [1:0]       dir_code,
  output logic             dir_chg
);

  typedef enum logic [2:0] {ARM, WAIT_RISE, HIGH, LOW, STATIC} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             pwm_s1, pwm_s, pwm_p;
  logic             a_s1, a_s, b_s1, b_s;
  state_t           state, state_d;
  logic [1:0]       arm_cnt, arm_cnt_d;
  logic [CNT_W-1:0] hc, hc_d, pc, pc_d, idle, idle_d;
  logic [CNT_W-1:0] high_cnt_d, period_cnt_d;
  logic             meas_valid_d, static_det_d, static_lvl_d;
  logic             go_static;
  logic             rise, fall, timeout;

  assign rise    = pwm_s & ~pwm_p;
  assign fall    = ~pwm_s & pwm_p;
  // A rise or fall in the deciding cycle always beats the timeout.
  assign timeout = ~(rise | fall) && (idle == IDLE_LAST);

  // NOTE: every flop uses non-blocking assignment so all registers update
  // together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_s1   <= 1'b0;
      pwm_s    <= 1'b0;
      pwm_p    <= 1'b0;
      a_s1     <= 1'b0;
      a_s      <= 1'b0;
      b_s1     <= 1'b0;
      b_s      <= 1'b0;
      dir_code <= 2'b00;
      dir_chg  <= 1'b0;
    end else begin
      pwm_s1   <= pwm_in;
      pwm_s    <= pwm_s1;
      pwm_p    <= pwm_s;
      a_s1     <= dir_a;
      a_s      <= a_s1;
      b_s1     <= dir_b;
      b_s      <= b_s1;
      dir_code <= {b_s, a_s};
      dir_chg  <= ({b_s, a_s} != dir_code);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARM;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_cnt    <= 2'd0;
      hc         <= '0;
      pc         <= '0;
      idle       <= '0;
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      static_det <= 1'b0;
      static_lvl <= 1'b0;
    end else begin
      arm_cnt    <= arm_cnt_d;
      hc         <= hc_d;
      pc         <= pc_d;
      idle       <= idle_d;
      meas_valid <= meas_valid_d;
      high_cnt   <= high_cnt_d;
      period_cnt <= period_cnt_d;
      static_det <= static_det_d;
      static_lvl <= static_lvl_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    arm_cnt_d    = arm_cnt;
    hc_d         = hc;
    pc_d         = pc;
    idle_d       = (rise | fall) ? '0 : sat_inc(idle);
    meas_valid_d = 1'b0;
    high_cnt_d   = high_cnt;
    period_cnt_d = period_cnt;
    static_det_d = static_det;
    static_lvl_d = static_lvl;
    go_static    = 1'b0;

    case (state)
      ARM: begin
        idle_d = '0;
        if (arm_cnt == 2'd2) state_d = WAIT_RISE;
        else                 arm_cnt_d = arm_cnt + 2'd1;
      end
      WAIT_RISE: begin
        if (rise) begin
          hc_d    = CNT_ONE;
          pc_d    = CNT_ONE;
          state_d = HIGH;
        end else if (timeout) begin
          go_static = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          pc_d    = sat_inc(pc);
          state_d = LOW;
        end else if (timeout) begin
          go_static = 1'b1;
        end else begin
          hc_d = sat_inc(hc);
          pc_d = sat_inc(pc);
        end
      end
      LOW: begin
        if (rise) begin
          high_cnt_d   = hc;
          period_cnt_d = pc;
          static_det_d = 1'b0;
          meas_valid_d = 1'b1;
          hc_d         = CNT_ONE;
          pc_d         = CNT_ONE;
          state_d      = HIGH;
        end else if (timeout) begin
          go_static = 1'b1;
        end else begin
          pc_d = sat_inc(pc);
        end
      end
      STATIC: begin
        if (rise) begin
          hc_d    = CNT_ONE;
          pc_d    = CNT_ONE;
          state_d = HIGH;
        end else if (fall) begin
          state_d = WAIT_RISE;
        end
      end
      default: state_d = ARM;
    endcase

    // The open period, if any, is abandoned rather than published.
    if (go_static) begin
      high_cnt_d   = '0;
      period_cnt_d = '0;
      static_det_d = 1'b1;
      static_lvl_d = pwm_s;
      meas_valid_d = 1'b1;
      state_d      = STATIC;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM/direction stimulus checked every
// cycle against an edge-timestamp reference model.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int MAXC    = 8192;

  logic             clk = 1'b0;
  logic             rst_n, pwm_in, dir_a, dir_b;
  logic             meas_valid, static_det, static_lvl, dir_chg;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [1:0]       dir_code;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .dir_a      (dir_a),
    .dir_b      (dir_b),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .static_det (static_det),
    .static_lvl (static_lvl),
    .dir_code   (dir_code),
    .dir_chg    (dir_chg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit checking = 1'b0;
  int strobe_cnt = 0;
  int chg_cnt = 0;
  int first_high = -1;
  int first_period = -1;

  // Reference model: input history plus timestamps of the open period.
  bit         x_hist [MAXC];
  logic [1:0] d_hist [MAXC];
  int  rst_at = -100;
  int  last_edge = 0;
  int  rise_t = 0;
  int  fall_t = 0;
  bit  open = 1'b0;
  bit  fall_seen = 1'b0;
  bit  is_static = 1'b0;
  bit  e_mv = 1'b0;
  int  e_high = 0;
  int  e_period = 0;
  bit  e_det = 1'b0;
  bit  e_lvl = 1'b0;
  logic [1:0] e_code = 2'b00;
  bit  e_chg = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called at each posedge with the values the DUT is sampling there. Results
  // decided on input sample n appear after the edge two cycles later.
  task automatic model_step();
    int n;
    bit rise, fall;
    logic [1:0] code;
    x_hist[cyc] = pwm_in;
    d_hist[cyc] = {dir_b, dir_a};
    e_mv = 1'b0;
    if (!rst_n) begin
      checking  = 1'b1;
      rst_at    = cyc;
      last_edge = cyc + 1;
      open      = 1'b0;
      fall_seen = 1'b0;
      is_static = 1'b0;
      e_high    = 0;
      e_period  = 0;
      e_det     = 1'b0;
      e_lvl     = 1'b0;
      e_code    = 2'b00;
      e_chg     = 1'b0;
      return;
    end
    if (!checking) return;
    n = cyc - 2;
    if (n >= rst_at + 2) begin
      rise = x_hist[n] && !x_hist[n-1];
      fall = !x_hist[n] && x_hist[n-1];
      if (rise) begin
        if (open && fall_seen) begin
          e_mv = 1'b1; e_high = fall_t - rise_t; e_period = n - rise_t; e_det = 1'b0;
        end
        open = 1'b1; fall_seen = 1'b0; rise_t = n; is_static = 1'b0; last_edge = n;
      end else if (fall) begin
        if (open && !fall_seen) begin
          fall_seen = 1'b1; fall_t = n;
        end
        is_static = 1'b0; last_edge = n;
      end else if (!is_static && (n - last_edge) == TIMEOUT) begin
        e_mv = 1'b1; e_high = 0; e_period = 0; e_det = 1'b1; e_lvl = x_hist[n];
        open = 1'b0; is_static = 1'b1;
      end
    end
    code   = (n > rst_at) ? d_hist[n] : 2'b00;
    e_chg  = (code != e_code);
    e_code = code;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model_step();
    #1;
    if (checking) begin
      check("mv", 32'(meas_valid), 32'(e_mv));
      check("high", 32'(high_cnt), e_high);
      check("period", 32'(period_cnt), e_period);
      check("det", 32'(static_det), 32'(e_det));
      if (e_det) check("lvl", 32'(static_lvl), 32'(e_lvl));
      check("dir_code", 32'(dir_code), 32'(e_code));
      check("dir_chg", 32'(dir_chg), 32'(e_chg));
    end
    if (meas_valid === 1'b1) begin
      if (strobe_cnt == 0) begin
        first_high   = int'(high_cnt);
        first_period = int'(period_cnt);
      end
      strobe_cnt++;
    end
    if (dir_chg === 1'b1) chg_cnt++;
  endtask

  task automatic hold(input bit level, input int cycles);
    pwm_in = level;
    repeat (cycles) tick();
  endtask

  task automatic train(input int h, input int l, input int reps);
    repeat (reps) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic dir_step(input bit a, input bit b, input logic [1:0] old_code,
                          input logic [1:0] new_code);
    dir_a = a;
    dir_b = b;
    tick();
    tick();
    check("dir_before", 32'(dir_code), 32'(old_code));
    tick();
    check("dir_after", 32'(dir_code), 32'(new_code));
    check("dir_pulse", 32'(dir_chg), 1);
    tick();
    check("dir_pulse_end", 32'(dir_chg), 0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; pwm_in = 1'b0; dir_a = 1'b0; dir_b = 1'b0;
    repeat (3) tick();
    check("rst_mv", 32'(meas_valid), 0);
    check("rst_high", 32'(high_cnt), 0);
    check("rst_period", 32'(period_cnt), 0);
    check("rst_det", 32'(static_det), 0);
    check("rst_lvl", 32'(static_lvl), 0);
    check("rst_code", 32'(dir_code), 0);
    rst_n = 1'b1;
    hold(1'b0, 8);

    // 7-high / 10-period train, then the 3-edge strobe latency.
    train(7, 3, 5);
    pwm_in = 1'b1;
    tick();
    tick();
    check("lat_early", 32'(meas_valid), 0);
    tick();
    check("lat_3rd_edge", 32'(meas_valid), 1);
    check("t1_high", 32'(high_cnt), 7);
    check("t1_period", 32'(period_cnt), 10);
    check("t1_det", 32'(static_det), 0);
    hold(1'b1, 4);
    hold(1'b0, 3);

    // Width switch at a period boundary.
    train(3, 7, 4);
    train(5, 5, 4);

    // Static high, then static low.
    pwm_in = 1'b1;
    repeat (5) tick();
    strobe_cnt = 0;
    hold(1'b1, TIMEOUT + 20);
    check("st1_strobes", strobe_cnt, 1);
    check("st1_det", 32'(static_det), 1);
    check("st1_lvl", 32'(static_lvl), 1);
    check("st1_counts", 32'({high_cnt, period_cnt}), 0);
    strobe_cnt = 0;
    hold(1'b0, TIMEOUT + 20);
    check("st0_strobes", strobe_cnt, 1);
    check("st0_det", 32'(static_det), 1);
    check("st0_lvl", 32'(static_lvl), 0);

    // Line high across reset release.
    pwm_in = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    strobe_cnt = 0;
    hold(1'b1, 10);
    hold(1'b0, 3);
    check("hr_no_strobe", strobe_cnt, 0);
    train(7, 3, 2);
    pwm_in = 1'b1;
    repeat (3) tick();
    check("hr_strobes", strobe_cnt, 2);
    check("hr_first_high", first_high, 7);
    check("hr_first_period", first_period, 10);

    // Reset pulse in the middle of a high phase.
    hold(1'b1, 4);
    rst_n = 1'b0;
    tick();
    check("mr_mv", 32'(meas_valid), 0);
    check("mr_high", 32'(high_cnt), 0);
    check("mr_period", 32'(period_cnt), 0);
    rst_n = 1'b1;
    strobe_cnt = 0;
    hold(1'b1, 3);
    hold(1'b0, 3);
    pwm_in = 1'b1;
    repeat (4) tick();
    check("mr_truncated", strobe_cnt, 0);
    hold(1'b1, 3);
    hold(1'b0, 3);

    // Direction pin steps.
    chg_cnt = 0;
    dir_step(1'b1, 1'b0, 2'b00, 2'b01);
    dir_step(1'b0, 1'b1, 2'b01, 2'b10);
    dir_step(1'b1, 1'b1, 2'b10, 2'b11);
    dir_step(1'b0, 1'b0, 2'b11, 2'b00);
    check("dir_chg_count", chg_cnt, 4);

    // Random mix of pulses, long holds, direction changes and resets.
    while (cyc < 6000) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) begin
        dir_a = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) tick();
        dir_b = 1'($urandom_range(0, 1));
      end
      if (r < 3) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst_n = 1'b1;
      end else if (r < 10) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(40, 110));
      end else begin
        hold(1'b1, $urandom_range(1, 12));
        hold(1'b0, $urandom_range(1, 12));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
